traffic_request_conditioner: RTL and testbench
==============================================

# traffic_request_conditioner

Upstream input stage for the traffic light controller. Conditions a raw asynchronous pedestrian push-button into a clean, latched crossing request. The request is held until the controller grants the walk phase. An optional wait timer escalates long-ignored requests to an urgent flag that the controller uses to shorten its green phase.

## Interface
- `DEBOUNCE_CYCLES`, default 16: cycles the synchronized button must hold a new level before it is accepted. Must be ≥ 1.
- `MAX_WAIT`, default 200: cycles a request may stay pending before `urgent` asserts. Must be ≥ 2.
- `WAIT_W`, default `$clog2(MAX_WAIT+1)`: width of `wait_count`. Derived; do not override.
- `clock`  in  1  single rising-edge clock.
- `reset`  in  1  asynchronous, active-low; the block is held in reset while it is 0.
- `button_raw`  in  1  raw push-button level, asynchronous to `clock`, may bounce.
- `grant`  in  1  one-cycle pulse from the controller when the walk phase starts.
- `button_clean`  out  1  debounced button level.
- `request`  out  1  crossing request pending.
- `urgent`  out  1  request has waited `MAX_WAIT` cycles.
- `wait_count`  out  `WAIT_W`  cycles elapsed since `request` rose; saturates at `MAX_WAIT`.

## Operation
- **Input path:** 2-flop synchronizer `button_raw` → `sync1` → `sync2`.
- **Debounce counter `db_cnt`:**
  - Each edge where `sync2 == button_clean`: `db_cnt` is cleared to 0.
  - Otherwise, if `db_cnt == DEBOUNCE_CYCLES-1`: `button_clean <= sync2` and `db_cnt <= 0`.
  - Otherwise `db_cnt` increments.
  - A bounce shorter than `DEBOUNCE_CYCLES` cycles never changes `button_clean`.
- **Press event:** rising edge of `button_clean`, detected with a registered copy of `button_clean`.
- **State machine** (states IDLE, PENDING, URGENT, SERVED):
  - IDLE: on a press event → PENDING, with `wait_count <= 0`. `grant` is ignored.
  - PENDING: `wait_count` increments every edge.
    - `grant` → SERVED.
    - Else, if `wait_count == MAX_WAIT-1` → URGENT, with `wait_count` = `MAX_WAIT`.
  - URGENT: `wait_count` holds at `MAX_WAIT`. `grant` → SERVED.
  - SERVED: `wait_count <= 0`. When `button_clean == 0` → IDLE; otherwise stay. A held button cannot retrigger a request.
- **Outputs:** registered, decoded from the state.
  - `request` = 1 in PENDING or URGENT.
  - `urgent` = 1 in URGENT only.
- **Simultaneous events:**
  - `grant` and timeout on the same edge: grant wins (→ SERVED).
  - Press and `grant` on the same edge in IDLE: press wins (→ PENDING).
  - A press while in PENDING or URGENT is absorbed; there is no counter reset and no second request.
- **Reset (async, `reset == 0`):**
  - State → IDLE.
  - `sync1`, `sync2`, `button_clean`, `db_cnt`, `wait_count` all → 0.
  - `request` = 0 and `urgent` = 0 immediately.
  - Reset mid-request drops the request; no stale request survives.

## Timing
- Count edge 1 as the first edge that samples a settled `button_raw`. `button_clean` changes on edge `DEBOUNCE_CYCLES+2`.
- `request` rises one edge after `button_clean` rises: edge `DEBOUNCE_CYCLES+3`.
- `urgent` rises exactly `MAX_WAIT` edges after `request` rises, provided no `grant` arrives.
- `request` and `urgent` fall on the edge that samples `grant == 1`.
- Release latency matches press latency: `DEBOUNCE_CYCLES+2` edges.

## Configuration
- `TRAFFIC_REQ_URGENT_EN` defined:
  - Wait timer and URGENT state are present, as described above.
- `TRAFFIC_REQ_URGENT_EN` undefined:
  - URGENT state and wait counter are removed.
  - `urgent` and `wait_count` are tied to 0.
  - PENDING is left only via `grant`.
  - All other behaviour is unchanged.

## Test plan
Bench uses `DEBOUNCE_CYCLES`=4, `MAX_WAIT`=10, with `TRAFFIC_REQ_URGENT_EN` defined unless stated.
- **Reset:** drive `reset`=0 mid-cycle with the block in URGENT → `request`, `urgent`, `wait_count` go to 0 immediately. After release with the button low, stays IDLE.
- **Bounce rejection:** toggle `button_raw` high for 3 cycles, low 2, high 2, low → `button_clean` and `request` stay 0 throughout.
- **Clean press:** raise `button_raw` and hold → `button_clean`=1 at edge 6 and `request`=1 at edge 7. Pulse `grant` 3 cycles later → `request`=0 next edge, `urgent` never set.
- **Urgent:** press and never grant → `urgent`=1 exactly 10 edges after `request` rises, `wait_count`=10 and holding. `grant` then clears both.
- **Hold after grant:** keep the button held through `grant` → state SERVED, `request` stays 0. Release and re-press → a new request rises 7 edges after the re-press.
- **Simultaneous grant and timeout:** assert `grant` on the edge where `wait_count`=9 → SERVED, `urgent` never asserts. Rebuild without the macro and run the Urgent scenario → `urgent`=0 and `wait_count`=0 for 50+ cycles, `request` held.

Source files
------------

// File: rtl/traffic_request_conditioner_if.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_request_conditioner_if
//  Description : Bundles the pedestrian-button request signals exchanged
//                between the button-side driver and the request conditioner.
//                  button_raw   : raw push-button level (driver -> conditioner)
//                  grant        : walk-phase start pulse (driver -> conditioner)
//                  button_clean : debounced button level
//                  request      : crossing request pending
//                  urgent       : request has waited the maximum time
//                  wait_count   : cycles elapsed since request rose
//                Modports: master (driver side), slave (conditioner side).
//  Revision    : 1.0  initial release
// ============================================================================
interface traffic_request_conditioner_if #(
    parameter int WAIT_W = 8
);
    logic              button_raw;
    logic              grant;
    logic              button_clean;
    logic              request;
    logic              urgent;
    logic [WAIT_W-1:0] wait_count;

    modport master (
        output button_raw,
        output grant,
        input  button_clean,
        input  request,
        input  urgent,
        input  wait_count
    );

    modport slave (
        input  button_raw,
        input  grant,
        output button_clean,
        output request,
        output urgent,
        output wait_count
    );
endinterface
`default_nettype wire

// File: rtl/traffic_request_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_request_conditioner
//  Description : Turns a raw, bouncing, asynchronous pedestrian push-button
//                into a clean latched crossing request that is held until
//                the controller grants the walk phase. Optionally escalates a
//                long-ignored request to an urgent flag.
//  Ports       : clock  - rising-edge clock
//                reset  - asynchronous, active-low reset
//                bus    - traffic_request_conditioner_if.slave
//                         (button_raw, grant in; button_clean, request,
//                          urgent, wait_count out)
//  Parameters  : DEBOUNCE_CYCLES (>=1), MAX_WAIT (>=2), WAIT_W (derived)
//  Build macro : TRAFFIC_REQ_URGENT_EN - when defined, the wait timer and the
//                URGENT state are built; otherwise urgent and wait_count are
//                tied to 0 and PENDING is left only through grant.
//  Revision    : 1.0  initial release
// ============================================================================
module traffic_request_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MAX_WAIT        = 200,
    parameter int WAIT_W          = $clog2(MAX_WAIT + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    traffic_request_conditioner_if.slave bus
);

    localparam int c_db_w = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_db_w-1:0] c_db_last = c_db_w'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_PENDING = 2'd1,
`ifdef TRAFFIC_REQ_URGENT_EN
        S_URGENT  = 2'd2,
`endif
        S_SERVED  = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Synchronizer and debouncer
    // ------------------------------------------------------------------------
    logic              r_sync1;
    logic              r_sync2;
    logic              r_clean;
    logic              r_clean_d;
    logic [c_db_w-1:0] r_db_cnt;
    logic              w_press;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_clean   <= 1'b0;
            r_clean_d <= 1'b0;
            r_db_cnt  <= '0;
        end else begin
            r_sync1   <= bus.button_raw;
            r_sync2   <= r_sync1;
            r_clean_d <= r_clean;
            // Any return to the accepted level restarts the stability window,
            // so a bounce shorter than DEBOUNCE_CYCLES never gets through.
            if (r_sync2 == r_clean) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_db_last) begin
                r_clean  <= r_sync2;
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + 1'b1;
            end
        end
    end

    assign w_press = r_clean & ~r_clean_d;

    // ------------------------------------------------------------------------
    // Request state machine
    // ------------------------------------------------------------------------
    state_t r_state;
    state_t w_state_nxt;
    logic   r_request;
    logic   r_urgent;

`ifdef TRAFFIC_REQ_URGENT_EN
    localparam logic [WAIT_W-1:0] c_wait_last = WAIT_W'(MAX_WAIT - 1);
    localparam logic [WAIT_W-1:0] c_wait_max  = WAIT_W'(MAX_WAIT);

    logic [WAIT_W-1:0] r_wait;
    logic [WAIT_W-1:0] w_wait_nxt;
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // A press beats a coincident grant: grant is ignored in IDLE.
            S_IDLE: begin
                if (w_press) begin
                    w_state_nxt = S_PENDING;
                end
            end
            // Grant beats a coincident timeout; further presses are absorbed.
            S_PENDING: begin
                if (bus.grant) begin
                    w_state_nxt = S_SERVED;
`ifdef TRAFFIC_REQ_URGENT_EN
                end else if (r_wait == c_wait_last) begin
                    w_state_nxt = S_URGENT;
`endif
                end
            end
`ifdef TRAFFIC_REQ_URGENT_EN
            S_URGENT: begin
                if (bus.grant) begin
                    w_state_nxt = S_SERVED;
                end
            end
`endif
            // Wait for release so a held button cannot raise a second request.
            S_SERVED: begin
                if (!r_clean) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

`ifdef TRAFFIC_REQ_URGENT_EN
    // Wait counter follows the destination state: zero on entry to PENDING,
    // counting while PENDING persists, pinned at MAX_WAIT in URGENT.
    always_comb begin
        w_wait_nxt = '0;
        case (w_state_nxt)
            S_PENDING: begin
                if (r_state == S_PENDING) begin
                    w_wait_nxt = r_wait + 1'b1;
                end
            end
            S_URGENT: begin
                w_wait_nxt = c_wait_max;
            end
            default: begin
                w_wait_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_wait <= '0;
        end else begin
            r_wait <= w_wait_nxt;
        end
    end
`endif

    // Outputs are decoded from the next state so they are registered yet
    // change on the same edge as the state register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_request <= 1'b0;
            r_urgent  <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_request <= (w_state_nxt == S_PENDING)
`ifdef TRAFFIC_REQ_URGENT_EN
                      || (w_state_nxt == S_URGENT)
`endif
                      ;
`ifdef TRAFFIC_REQ_URGENT_EN
            r_urgent  <= (w_state_nxt == S_URGENT);
`else
            r_urgent  <= 1'b0;
`endif
        end
    end

    assign bus.button_clean = r_clean;
    assign bus.request      = r_request;
    assign bus.urgent       = r_urgent;
`ifdef TRAFFIC_REQ_URGENT_EN
    assign bus.wait_count   = r_wait;
`else
    assign bus.wait_count   = {WAIT_W{1'b0}};
`endif

endmodule
`default_nettype wire

// File: tb/tb_traffic_request_conditioner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_request_conditioner
//  Description : Directed bench for traffic_request_conditioner with
//                DEBOUNCE_CYCLES=4, MAX_WAIT=10. Expected values are queued
//                against an edge number when stimulus is applied and compared
//                once that edge has been reached. Expectations for the urgent
//                path follow TRAFFIC_REQ_URGENT_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_traffic_request_conditioner;

    localparam int D = 4;
    localparam int M = 10;
    localparam int W = $clog2(M + 1);

`ifdef TRAFFIC_REQ_URGENT_EN
    localparam int URG_EN = 1;
`else
    localparam int URG_EN = 0;
`endif

    localparam int K_CLEAN = 0;
    localparam int K_REQ   = 1;
    localparam int K_URG   = 2;
    localparam int K_WC    = 3;

    typedef struct {
        int    due;
        int    kind;
        int    val;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   edge_n = 0;

    logic clock = 1'b0;
    logic reset = 1'b0;

    traffic_request_conditioner_if #(.WAIT_W(W)) bus ();

    traffic_request_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .MAX_WAIT       (M)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] observe(int kind);
        case (kind)
            K_CLEAN: return {31'b0, bus.button_clean};
            K_REQ:   return {31'b0, bus.request};
            K_URG:   return {31'b0, bus.urgent};
            K_WC:    return 32'(bus.wait_count);
            default: return '1;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push(int offset, int kind, int val, string tag);
        exp_t e;
        e.due  = edge_n + offset;
        e.kind = kind;
        e.val  = val;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    task automatic push_range(int from, int to, int kind, int val, string tag);
        for (int k = from; k <= to; k++) push(k, kind, val, tag);
    endtask

    task automatic service();
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == edge_n) begin
                check($sformatf("%s@%0d", sb[i].tag, edge_n),
                      observe(sb[i].kind), 32'(sb[i].val));
                sb.delete(i);
            end
        end
    endtask

    task automatic tick(int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
            edge_n++;
            service();
        end
    endtask

    initial begin
        bus.button_raw = 1'b0;
        bus.grant      = 1'b0;
        reset          = 1'b0;

        // Reset state
        #2;
        check("rst_clean", observe(K_CLEAN), 0);
        check("rst_req",   observe(K_REQ),   0);
        check("rst_urg",   observe(K_URG),   0);
        check("rst_wc",    observe(K_WC),    0);
        tick(2);
        reset = 1'b1;
        tick(3);

        // Bounce rejection: high 3, low 2, high 2, low
        push_range(1, 20, K_CLEAN, 0, "bounce_clean");
        push_range(1, 20, K_REQ,   0, "bounce_req");
        bus.button_raw = 1'b1; tick(3);
        bus.button_raw = 1'b0; tick(2);
        bus.button_raw = 1'b1; tick(2);
        bus.button_raw = 1'b0; tick(13);

        // Clean press, grant three cycles after request
        push(5, K_CLEAN, 0, "press_clean_early");
        push(6, K_CLEAN, 1, "press_clean");
        push(6, K_REQ,   0, "press_req_early");
        push(7, K_REQ,   1, "press_req");
        push(7, K_WC,    0, "press_wc");
        push(9, K_REQ,   1, "req_before_grant");
        push(9, K_WC,    URG_EN ? 2 : 0, "wc_before_grant");
        push_range(7, 9, K_URG, 0, "press_urg");
        bus.button_raw = 1'b1;
        tick(9);
        bus.grant = 1'b1;
        push(1, K_REQ, 0, "grant_req");
        push(1, K_URG, 0, "grant_urg");
        tick(1);
        bus.grant = 1'b0;

        // Button held through grant: no new request
        push_range(1, 5, K_REQ, 0, "held_req");
        push(2, K_WC, 0, "served_wc");
        tick(5);

        // Release, then re-press
        bus.button_raw = 1'b0;
        push(5, K_CLEAN, 1, "rel_clean_early");
        push(6, K_CLEAN, 0, "rel_clean");
        tick(8);
        bus.button_raw = 1'b1;
        push(6, K_REQ, 0, "repress_req_early");
        push(7, K_REQ, 1, "repress_req");
        tick(7);

        // Urgent escalation (request rose on this edge), never granted
        push(9,  K_URG, 0, "urg_early");
        push(9,  K_WC,  URG_EN ? 9 : 0, "wc_9");
        push(10, K_URG, URG_EN, "urg_rise");
        push(10, K_WC,  URG_EN ? 10 : 0, "wc_10");
        push_range(11, 55, K_URG, URG_EN, "urg_hold");
        push_range(11, 55, K_WC,  URG_EN ? 10 : 0, "wc_hold");
        push_range(1, 55, K_REQ, 1, "req_hold");
        tick(55);
        bus.grant = 1'b1;
        push(1, K_REQ, 0, "urg_grant_req");
        push(1, K_URG, 0, "urg_grant_urg");
        push(1, K_WC,  0, "urg_grant_wc");
        tick(1);
        bus.grant = 1'b0;
        bus.button_raw = 1'b0;
        tick(10);

        // Grant on the same edge as the timeout
        bus.button_raw = 1'b1;
        push(7, K_REQ, 1, "sim_req");
        tick(7);
        push(9, K_WC, URG_EN ? 9 : 0, "sim_wc9");
        tick(9);
        bus.grant = 1'b1;
        push_range(1, 5, K_URG, 0, "sim_urg");
        push_range(1, 5, K_REQ, 0, "sim_req_drop");
        tick(1);
        bus.grant = 1'b0;
        tick(4);
        bus.button_raw = 1'b0;
        tick(10);

        // Asynchronous reset while the request is urgent
        bus.button_raw = 1'b1;
        push(7, K_REQ, 1, "pre_rst_req");
        tick(7);
        push(12, K_URG, URG_EN, "pre_rst_urg");
        tick(12);
        #3;
        reset = 1'b0;
        #1;
        check("async_rst_req",   observe(K_REQ),   0);
        check("async_rst_urg",   observe(K_URG),   0);
        check("async_rst_wc",    observe(K_WC),    0);
        check("async_rst_clean", observe(K_CLEAN), 0);
        bus.button_raw = 1'b0;
        tick(2);
        reset = 1'b1;
        push_range(1, 15, K_REQ,   0, "post_rst_req");
        push_range(1, 15, K_CLEAN, 0, "post_rst_clean");
        tick(15);

        check("sb_drain", 32'(sb.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
